alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Multi-cycle sequencer that drives the shared 8-bit combinational ALU to run
//  16-bit add (ADD16) and 8x8->16 unsigned multiply (MUL8) commands.
//  Takes commands on a valid/ready port, issues one ALU ADD per cycle, registers
//  ALU results and returns a 16-bit result on a valid/ready response port.
//  Sits between the core's execute stage and the ALU instance; owns alu_op/A/B while busy.
// PARAMETERS
//  DATA_W   8        ALU datapath width; results are 2*DATA_W bits
//  OP_ADD   4'b0001  ALU opcode for add; flags[2] is carry-out
//  OP_NOP   4'b0000  ALU opcode driven when idle (ALU outputs 0)
// PORTS
//  clk        in   1   clock; all state changes on rising edge
//  reset      in   1   synchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   sequencer can accept a command
//  cmd_op     in   2   00=ADD16, 01=MUL8, 1x=reserved (error)
//  cmd_a      in   16  operand A (MUL8 uses [7:0] only)
//  cmd_b      in   16  operand B (MUL8 uses [7:0] only)
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer takes response
//  rsp_data   out  16  result
//  rsp_carry  out  1   ADD16 carry-out of bit 15; 0 for MUL8 and error
//  rsp_err    out  1   reserved opcode was accepted
//  alu_op     out  4   to ALU opcode input
//  alu_a      out  8   to ALU input_A
//  alu_b      out  8   to ALU input_B
//  alu_out    in   8   from ALU out (same-cycle, combinational)
//  alu_flags  in   3   from ALU flags {c,n,z}
// BEHAVIOUR
//  - States: IDLE, ADD_LO, ADD_HI, ADD_INC, MUL, DONE.
//  - Reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0,
//    rsp_err=0, alu_op=OP_NOP, alu_a=0, alu_b=0, all internal registers 0.
//  - cmd_ready=1 only in IDLE. Accept when cmd_valid&&cmd_ready; operands are
//    latched on that edge. cmd_valid is ignored in every other state.
//  - ADD16: ADD_LO: a=A[7:0], b=B[7:0] -> lo, c0. ADD_HI: a=A[15:8], b=B[15:8] -> h, c1.
//    ADD_INC: a=h, b={7'b0,c0} -> hi, c2. rsp_data={hi,lo}, rsp_carry=c1|c2.
//    c1 and c2 are never both 1.
//  - MUL8: P_hi=0, P_lo=B[7:0], M=A[7:0], cnt=0 on accept. Each MUL cycle:
//    alu_op=OP_ADD, alu_a=P_hi, alu_b=P_lo[0]?M:0.
//    Next P_hi={c,alu_out[7:1]}, P_lo={alu_out[0],P_lo[7:1]}, cnt++.
//    After the 8th MUL cycle go to DONE. rsp_data={P_hi,P_lo}, rsp_carry=0.
//  - Reserved op: IDLE -> DONE directly; rsp_err=1, rsp_data=0.
//  - Compute states drive alu_op=OP_ADD. IDLE and DONE drive OP_NOP, a=b=0.
//  - Latency from accept edge (cycle 0): ADD16 rsp_valid at cycle 4,
//    MUL8 at cycle 9, error at cycle 1.
//  - DONE: rsp_valid=1. rsp_* hold stable until rsp_valid&&rsp_ready, then IDLE.
//    No same-cycle re-accept: next command can be taken in the following IDLE cycle.
//  - Reset asserted in any state, including mid-operation, wins over all other
//    events. The next edge gives reset values and aborts the command with no response.
// TESTING
//  1. ADD16 0x12FF+0x0001, rsp_ready=1 -> rsp_valid at cycle 4; data 0x1300, carry 0, err 0.
//  2. ADD16 0xFFFF+0x0001 -> 0x0000, carry 1. ADD16 0x80FF+0x8001 -> 0x0100, carry 1.
//  3. MUL8 0xFF*0xFF -> 0xFE01 at cycle 9. MUL8 0x00*0x5A -> 0x0000.
//     MUL8 0x0D*0x0B -> 0x008F. alu_op=0001 exactly 8 cycles.
//  4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> data/carry stable,
//     cmd_ready=0; a cmd_valid pulse is ignored; IDLE one cycle after rsp_ready=1.
//  5. Assert reset during MUL cycle 4 -> next cycle: cmd_ready=1, rsp_valid=0,
//     alu_op=0000; no response ever appears.
//  6. cmd_op=2'b10 -> rsp_valid at cycle 1; rsp_err=1, rsp_data=0, rsp_carry=0;
//     alu_op stays 0000 throughout.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Drives a shared 8-bit combinational ALU over several cycles
//               to run 16-bit ADD16 and 8x8->16 unsigned MUL8 commands.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int          DATA_W = 8,
    parameter logic [3:0]  OP_ADD = 4'b0001,
    parameter logic [3:0]  OP_NOP = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [2*DATA_W-1:0]   cmd_a,
    input  logic [2*DATA_W-1:0]   cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic [3:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [2:0]            alu_flags
);

    localparam int                 c_CNT_W    = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADD_LO  = 3'd1,
        S_ADD_HI  = 3'd2,
        S_ADD_INC = 3'd3,
        S_MUL     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2*DATA_W-1:0]   r_a;
    logic [2*DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_c0;
    logic                  r_carry;
    logic                  r_err;
    logic [c_CNT_W-1:0]    r_cnt;

    logic                  w_c;
    logic                  w_unused_flags;

    assign w_c            = alu_flags[2];
    assign w_unused_flags = ^alu_flags[1:0];

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_data  = {r_hi, r_lo};
    assign rsp_carry = r_carry;
    assign rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_c0    <= 1'b0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_hi    <= '0;
                        // MUL8 keeps the multiplier in the low half of the product register
                        r_lo    <= (cmd_op == 2'b01) ? cmd_b[DATA_W-1:0] : '0;
                        r_c0    <= 1'b0;
                        r_carry <= 1'b0;
                        r_err   <= cmd_op[1];
                        r_cnt   <= '0;
                    end
                end
                S_ADD_LO: begin
                    r_lo <= alu_out;
                    r_c0 <= w_c;
                end
                S_ADD_HI: begin
                    r_hi    <= alu_out;
                    r_carry <= w_c;
                end
                S_ADD_INC: begin
                    r_hi    <= alu_out;
                    r_carry <= r_carry | w_c;
                end
                S_MUL: begin
                    r_hi  <= {w_c, alu_out[DATA_W-1:1]};
                    r_lo  <= {alu_out[0], r_lo[DATA_W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_op      = OP_NOP;
        alu_a       = '0;
        alu_b       = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00:   w_state_nxt = S_ADD_LO;
                        2'b01:   w_state_nxt = S_MUL;
                        default: w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_ADD_LO: begin
                alu_op      = OP_ADD;
                alu_a       = r_a[DATA_W-1:0];
                alu_b       = r_b[DATA_W-1:0];
                w_state_nxt = S_ADD_HI;
            end
            S_ADD_HI: begin
                alu_op      = OP_ADD;
                alu_a       = r_a[2*DATA_W-1:DATA_W];
                alu_b       = r_b[2*DATA_W-1:DATA_W];
                w_state_nxt = S_ADD_INC;
            end
            S_ADD_INC: begin
                alu_op      = OP_ADD;
                alu_a       = r_hi;
                alu_b       = {{(DATA_W-1){1'b0}}, r_c0};
                w_state_nxt = S_DONE;
            end
            S_MUL: begin
                alu_op = OP_ADD;
                alu_a  = r_hi;
                alu_b  = r_lo[0] ? r_a[DATA_W-1:0] : '0;
                if (r_cnt == c_MUL_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed bench for alu_seq with a behavioural 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_err;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;
    logic [2:0]  alu_flags;

    int vectors;
    int miscompares;
    int lat;
    int add_cycles;
    int seen_valid;

    alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_flags (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add with carry-out on flags[2], zero output otherwise
    always_comb begin
        logic [8:0] sum;
        sum       = 9'd0;
        alu_out   = 8'd0;
        alu_flags = 3'd0;
        if (alu_op == 4'b0001) begin
            sum       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_out   = sum[7:0];
            alu_flags = {sum[8], sum[7], (sum[7:0] == 8'd0)};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and waits (bounded) for the response; lat counts
    // cycles after the accept edge, add_cycles counts cycles with alu_op=ADD.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_a      = a;
        cmd_b      = b;
        tick();
        cmd_valid  = 1'b0;
        lat        = 1;
        add_cycles = 0;
        while (!rsp_valid && lat < 40) begin
            if (alu_op == 4'b0001) add_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic expect_rsp(input string tag, input int exp_lat, input int exp_adds,
                              input logic [15:0] d, input logic c, input logic e);
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_adds"},  32'(add_cycles), 32'(exp_adds));
        check({tag, "_data"},  32'(rsp_data), 32'(d));
        check({tag, "_carry"}, 32'(rsp_carry), 32'(c));
        check({tag, "_err"},   32'(rsp_err), 32'(e));
        tick();
        check({tag, "_idle"},  32'(cmd_ready), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_a       = 16'h0;
        cmd_b       = 16'h0;
        rsp_ready   = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd0);
        check("rst_alu_ab",    32'({alu_a, alu_b}), 32'd0);
        reset = 1'b0;
        tick();

        run_cmd(2'b00, 16'h12FF, 16'h0001);
        expect_rsp("add_12ff", 4, 3, 16'h1300, 1'b0, 1'b0);
        run_cmd(2'b00, 16'hFFFF, 16'h0001);
        expect_rsp("add_ffff", 4, 3, 16'h0000, 1'b1, 1'b0);
        run_cmd(2'b00, 16'h80FF, 16'h8001);
        expect_rsp("add_80ff", 4, 3, 16'h0100, 1'b1, 1'b0);

        run_cmd(2'b01, 16'h00FF, 16'h00FF);
        expect_rsp("mul_ffxff", 9, 8, 16'hFE01, 1'b0, 1'b0);
        run_cmd(2'b01, 16'hAB00, 16'h375A);
        expect_rsp("mul_00x5a", 9, 8, 16'h0000, 1'b0, 1'b0);
        run_cmd(2'b01, 16'h000D, 16'h000B);
        expect_rsp("mul_0dx0b", 9, 8, 16'h008F, 1'b0, 1'b0);

        run_cmd(2'b10, 16'h1234, 16'h0005);
        expect_rsp("err_op10", 1, 0, 16'h0000, 1'b0, 1'b1);
        run_cmd(2'b00, 16'h0001, 16'h0002);
        expect_rsp("add_after_err", 4, 3, 16'h0003, 1'b0, 1'b0);

        // Backpressure: response must hold while rsp_ready is low
        rsp_ready = 1'b0;
        run_cmd(2'b00, 16'h1234, 16'h0F0F);
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 2);
            cmd_op    = 2'b01;
            cmd_a     = 16'h0003;
            cmd_b     = 16'h0003;
            tick();
            check("bp_valid",     32'(rsp_valid), 32'd1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_data",      32'(rsp_data),  32'h2143);
            check("bp_carry",     32'(rsp_carry), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(cmd_ready), 32'd1);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("bp_no_phantom", 32'({cmd_ready, rsp_valid, alu_op}), 32'h20);

        // Reset mid-multiply aborts with no response
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_a     = 16'h000D;
        cmd_b     = 16'h000B;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mul_c4_op", 32'(alu_op), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_alu_op",    32'(alu_op),    32'd0);
        check("abort_rsp_data",  32'(rsp_data),  32'd0);
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid) seen_valid++;
        end
        check("abort_no_rsp", 32'(seen_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
